// File: rtl/encoder_channel_ctrl.sv
// Encoder channel controller: quadrature decode into pending counters, one shared
// saturating adder granted round-robin, each update published over valid/ready.
module encoder_channel_ctrl #(
  parameter int NUM_CH   = 3,
  parameter int DATA_LEN = 8,
  parameter int INC_STEP = 1,
  parameter int SATURATE = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          enc_a,
  input  logic [NUM_CH-1:0]          enc_b,
  input  logic [NUM_CH-1:0]          clear_ch,
  output logic [NUM_CH*DATA_LEN-1:0] values,
  output logic                       upd_valid,
  output logic [CW-1:0]              upd_ch,
  output logic [DATA_LEN-1:0]        upd_value,
  input  logic                       upd_ready
);

  localparam int SW = DATA_LEN + 4;
  localparam logic signed [SW-1:0] INC = SW'(INC_STEP);
  localparam logic signed [SW-1:0] VMAX = {4'b0000, {DATA_LEN{1'b1}}};
  localparam logic signed [2:0] P_MAX = 3'sb011;
  localparam logic signed [2:0] P_MIN = 3'sb100;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    PUBLISH
  } state_t;

  state_t state, state_nx;

  logic [NUM_CH-1:0]    old_a, old_b;
  logic [NUM_CH-1:0]    up, dn, dirty, req;
  logic signed [2:0]    pend [NUM_CH];
  logic [DATA_LEN-1:0]  val  [NUM_CH];
  logic [CW-1:0]        gch, rr_ptr, pick;
  logic                 found;
  int                   rr_int;
  logic signed [SW-1:0] pend_x, sum;
  logic [DATA_LEN-1:0]  new_val;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_dec
    logic [3:0] code;
    assign code = {enc_a[i], old_a[i], enc_b[i], old_b[i]};
    assign up[i] = (code == 4'b1000) || (code == 4'b0111);
    assign dn[i] = (code == 4'b0010) || (code == 4'b1101);
    assign req[i] = (pend[i] != 3'sd0) || dirty[i];
    assign values[i*DATA_LEN +: DATA_LEN] = val[i];
  end

  // First requester at or after rr_ptr, wrapping around.
  assign rr_int = int'(rr_ptr);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[(rr_int + k) % NUM_CH]) begin
        found = 1'b1;
        pick  = CW'((rr_int + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    pend_x  = {{(SW-3){pend[gch][2]}}, pend[gch]};
    sum     = $signed({4'b0000, val[gch]}) + pend_x * INC;
    new_val = sum[DATA_LEN-1:0];
    if (SATURATE != 0) begin
      if (sum < 0)
        new_val = '0;
      else if (sum > VMAX)
        new_val = '1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = UPDATE;
      UPDATE:  state_nx = PUBLISH;
      PUBLISH: if (upd_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign upd_valid = (state == PUBLISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gch       <= '0;
      rr_ptr    <= '0;
      upd_ch    <= '0;
      upd_value <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found)
        gch <= pick;
      // A clear landing on the granted channel publishes the cleared value.
      if (state == UPDATE) begin
        upd_ch    <= gch;
        upd_value <= clear_ch[gch] ? '0 : new_val;
      end
      if (state == PUBLISH && upd_ready)
        rr_ptr <= (int'(gch) == NUM_CH - 1) ? '0 : gch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      old_a <= '0;
      old_b <= '0;
      dirty <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend[i] <= 3'sd0;
        val[i]  <= '0;
      end
    end else begin
      old_a <= enc_a;
      old_b <= enc_b;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear_ch[i]) begin
          val[i]   <= '0;
          pend[i]  <= 3'sd0;
          dirty[i] <= 1'b1;
        end else if (state == UPDATE && gch == CW'(i)) begin
          val[i]   <= new_val;
          pend[i]  <= up[i] ? 3'sd1 : (dn[i] ? -3'sd1 : 3'sd0);
          dirty[i] <= 1'b0;
        end else if (up[i] && pend[i] != P_MAX) begin
          pend[i] <= pend[i] + 3'sd1;
        end else if (dn[i] && pend[i] != P_MIN) begin
          pend[i] <= pend[i] - 3'sd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_channel_ctrl.sv
// Bench for encoder_channel_ctrl: saturating and wrapping instances driven
// together and compared every cycle against a transaction-level model.
module tb_encoder_channel_ctrl;
  localparam int N    = 3;
  localparam int DL   = 8;
  localparam int INC  = 1;
  localparam int VMAX = (1 << DL) - 1;
  localparam int W    = N*DL + 3 + DL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] enc_a = '0;
  logic [N-1:0] enc_b = '0;
  logic [N-1:0] clear_ch = '0;
  logic upd_ready = 1'b1;
  logic [N*DL-1:0] values_s, values_w;
  logic uv_s, uv_w;
  logic [1:0] uc_s, uc_w;
  logic [DL-1:0] uval_s, uval_w;
  logic [W-1:0] obs_s, obs_w;

  int checks = 0;
  int errors = 0;
  int mv [2][N];
  int mp [2][N];
  int md [2][N];
  int mst [2];
  int mg [2];
  int mrr [2];
  int muc [2];
  int muv [2];
  int oa [N];
  int ob [N];
  int pos [N];

  always #5 clk = ~clk;

  encoder_channel_ctrl #(
    .NUM_CH(N), .DATA_LEN(DL), .INC_STEP(INC), .SATURATE(1)
  ) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .clear_ch(clear_ch), .values(values_s), .upd_valid(uv_s),
    .upd_ch(uc_s), .upd_value(uval_s), .upd_ready(upd_ready)
  );

  encoder_channel_ctrl #(
    .NUM_CH(N), .DATA_LEN(DL), .INC_STEP(INC), .SATURATE(0)
  ) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .clear_ch(clear_ch), .values(values_w), .upd_valid(uv_w),
    .upd_ch(uc_w), .upd_value(uval_w), .upd_ready(upd_ready)
  );

  assign obs_s = {values_s, uv_s, uc_s, uval_s};
  assign obs_w = {values_w, uv_w, uc_w, uval_w};

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic logic [N*DL-1:0] exp_vals(input int k);
    logic [N*DL-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DL +: DL] = DL'(mv[k][i]);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_all(input int k);
    return {exp_vals(k), mst[k] == 2, 2'(muc[k]), DL'(muv[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        mv[k][i] = 0;
        mp[k][i] = 0;
        md[k][i] = 0;
      end
      mst[k] = 0;
      mg[k] = 0;
      mrr[k] = 0;
      muc[k] = 0;
      muv[k] = 0;
    end
    for (int i = 0; i < N; i++) begin
      oa[i] = 0;
      ob[i] = 0;
    end
  endtask

  // k=0 models the clamping instance, k=1 the wrapping one.
  task automatic model_step();
    int st [N];
    for (int i = 0; i < N; i++) begin
      int pv;
      int nw;
      pv = oa[i]*2 + ob[i];
      nw = int'(enc_a[i])*2 + int'(enc_b[i]);
      st[i] = 0;
      if ((pv == 0 && nw == 2) || (pv == 3 && nw == 1)) st[i] = 1;
      if ((pv == 0 && nw == 1) || (pv == 3 && nw == 2)) st[i] = -1;
    end
    for (int k = 0; k < 2; k++) begin
      int nv [N];
      int np [N];
      int nd [N];
      int nst;
      int g;
      int s;
      nst = mst[k];
      g = mg[k];
      for (int i = 0; i < N; i++) begin
        nv[i] = mv[k][i];
        nd[i] = md[k][i];
      end
      if (mst[k] == 0) begin
        for (int j = 0; j < N; j++) begin
          int c;
          c = (mrr[k] + j) % N;
          if (nst == 0 && (mp[k][c] != 0 || md[k][c] != 0)) begin
            mg[k] = c;
            nst = 1;
          end
        end
      end else if (mst[k] == 1) begin
        s = mv[k][g] + mp[k][g]*INC;
        if (k == 0) s = clampi(s, 0, VMAX);
        else s = ((s % (VMAX+1)) + VMAX + 1) % (VMAX+1);
        nv[g] = s;
        muc[k] = g;
        muv[k] = clear_ch[g] ? 0 : s;
        nst = 2;
      end else if (upd_ready) begin
        mrr[k] = (g + 1) % N;
        nst = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (mst[k] == 1 && i == g) begin
          np[i] = st[i];
          nd[i] = 0;
        end else begin
          np[i] = clampi(mp[k][i] + st[i], -4, 3);
        end
        if (clear_ch[i]) begin
          nv[i] = 0;
          np[i] = 0;
          nd[i] = 1;
        end
        mv[k][i] = nv[i];
        mp[k][i] = np[i];
        md[k][i] = nd[i];
      end
      mst[k] = nst;
    end
    for (int i = 0; i < N; i++) begin
      oa[i] = int'(enc_a[i]);
      ob[i] = int'(enc_b[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_enc();
    for (int i = 0; i < N; i++) begin
      enc_a[i] = (pos[i] == 1 || pos[i] == 2);
      enc_b[i] = (pos[i] == 2 || pos[i] == 3);
    end
  endtask

  // Walk the gray sequence; entering an odd position is a decoded step.
  task automatic move(input int ch, input int dir, input int n, input int hold);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    while (cnt < n && guard < 64) begin
      pos[ch] = (pos[ch] + dir + 4) % 4;
      set_enc();
      if (pos[ch] % 2 == 1) cnt++;
      repeat (hold) tick();
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_ch = '0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    set_enc();
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_s !== '0) begin
      errors++;
      $display("FAIL reset_s got %h exp 0", obs_s);
    end
    checks++;
    if (obs_w !== '0) begin
      errors++;
      $display("FAIL reset_w got %h exp 0", obs_w);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL reset_idle got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
  endtask

  task automatic test_single_up();
    int pubs;
    do_reset();
    upd_ready = 1'b1;
    pubs = 0;
    for (int ph = 0; ph < 4; ph++) begin
      pos[0] = (pos[0] + 1) % 4;
      set_enc();
      for (int t = 0; t < 2; t++) begin
        tick();
        checks++;
        if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
          errors++;
          $display("FAIL single_up got %h exp %h",
                   {obs_s, obs_w}, {exp_all(0), exp_all(1)});
        end
        if (ph == 1 && t == 1) begin
          checks++;
          if (values_s[DL-1:0] !== 8'd1) begin
            errors++;
            $display("FAIL single_first got %0d exp 1", values_s[DL-1:0]);
          end
        end
        if (uv_s) begin
          pubs++;
          checks++;
          if (uc_s !== 2'd0) begin
            errors++;
            $display("FAIL single_ch got %0d exp 0", uc_s);
          end
        end
      end
    end
    for (int t = 0; t < 6; t++) begin
      tick();
      if (uv_s) pubs++;
    end
    checks++;
    if (values_s[DL-1:0] !== 8'd2) begin
      errors++;
      $display("FAIL single_final got %0d exp 2", values_s[DL-1:0]);
    end
    checks++;
    if (pubs != 2) begin
      errors++;
      $display("FAIL single_pubs got %0d exp 2", pubs);
    end
  endtask

  task automatic test_saturate();
    int g;
    do_reset();
    upd_ready = 1'b1;
    move(0, -1, 2, 2);
    repeat (6) tick();
    checks++;
    if (values_s[DL-1:0] !== 8'd0 || values_w[DL-1:0] !== 8'd254) begin
      errors++;
      $display("FAIL sat_down got %0d/%0d exp 0/254",
               values_s[DL-1:0], values_w[DL-1:0]);
    end
    g = 0;
    while (mv[0][0] + mp[0][0] < 254 && g < 600) begin
      move(0, 1, 1, 2);
      g++;
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL sat_climb got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
    repeat (6) tick();
    checks++;
    if (values_s[DL-1:0] !== 8'd254 || values_w[DL-1:0] !== 8'd252) begin
      errors++;
      $display("FAIL sat_254 got %0d/%0d exp 254/252",
               values_s[DL-1:0], values_w[DL-1:0]);
    end
    move(0, 1, 3, 2);
    repeat (6) tick();
    checks++;
    if (values_s[DL-1:0] !== 8'd255 || values_w[DL-1:0] !== 8'd255) begin
      errors++;
      $display("FAIL sat_top got %0d/%0d exp 255/255",
               values_s[DL-1:0], values_w[DL-1:0]);
    end
    move(0, 1, 1, 2);
    repeat (6) tick();
    checks++;
    if (values_s[DL-1:0] !== 8'd255 || values_w[DL-1:0] !== 8'd0) begin
      errors++;
      $display("FAIL sat_wrap got %0d/%0d exp 255/0",
               values_s[DL-1:0], values_w[DL-1:0]);
    end
  endtask

  task automatic test_simultaneous();
    int q [$];
    do_reset();
    upd_ready = 1'b1;
    for (int i = 0; i < N; i++) pos[i] = 1;
    set_enc();
    for (int t = 0; t < 16; t++) begin
      tick();
      if (uv_s) q.push_back(int'(uc_s));
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL simul got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
    checks++;
    if (q.size() != 3 || q[0] != 0 || q[1] != 1 || q[2] != 2) begin
      errors++;
      $display("FAIL simul_order got %p exp 0 1 2", q);
    end
    q.delete();
    pos[0] = 2;
    pos[1] = 2;
    set_enc();
    repeat (2) tick();
    pos[0] = 3;
    pos[1] = 3;
    set_enc();
    for (int t = 0; t < 12; t++) begin
      tick();
      if (uv_s) q.push_back(int'(uc_s));
    end
    checks++;
    if (q.size() != 2 || q[0] != 0 || q[1] != 1) begin
      errors++;
      $display("FAIL pair_order got %p exp 0 1", q);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    upd_ready = 1'b0;
    for (int s = 0; s < 12; s++) begin
      pos[1] = (pos[1] + 1) % 4;
      set_enc();
      tick();
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL bp_steps got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
    for (int t = 0; t < 8; t++) begin
      tick();
      checks++;
      if (uv_s !== 1'b1 || uc_s !== 2'd1 || uval_s !== 8'd1) begin
        errors++;
        $display("FAIL bp_hold got v=%b ch=%0d val=%0d exp 1/1/1",
                 uv_s, uc_s, uval_s);
      end
    end
    upd_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL bp_drain got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
    checks++;
    if (values_s[2*DL-1:DL] !== 8'd4) begin
      errors++;
      $display("FAIL bp_final got %0d exp 4", values_s[2*DL-1:DL]);
    end
  endtask

  task automatic test_clear();
    int pubs;
    do_reset();
    upd_ready = 1'b1;
    move(2, 1, 9, 2);
    repeat (8) tick();
    checks++;
    if (values_s[3*DL-1:2*DL] !== 8'd9) begin
      errors++;
      $display("FAIL clr_pre got %0d exp 9", values_s[3*DL-1:2*DL]);
    end
    pos[2] = (pos[2] + 1) % 4;
    set_enc();
    repeat (2) tick();
    pos[2] = (pos[2] + 1) % 4;
    set_enc();
    clear_ch[2] = 1'b1;
    tick();
    clear_ch = '0;
    checks++;
    if (values_s[3*DL-1:2*DL] !== 8'd0) begin
      errors++;
      $display("FAIL clr_zero got %0d exp 0", values_s[3*DL-1:2*DL]);
    end
    pubs = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL clr_run got %h exp %h",
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
      if (uv_s) begin
        pubs++;
        checks++;
        if (uc_s !== 2'd2 || uval_s !== 8'd0) begin
          errors++;
          $display("FAIL clr_pub got ch=%0d val=%0d exp 2/0", uc_s, uval_s);
        end
      end
    end
    checks++;
    if (pubs != 1) begin
      errors++;
      $display("FAIL clr_count got %0d exp 1", pubs);
    end
  endtask

  task automatic test_reset_publish();
    bit seen;
    do_reset();
    upd_ready = 1'b0;
    pos[0] = 1;
    set_enc();
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      if (uv_s) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstpub_wait got timeout exp valid");
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    set_enc();
    model_reset();
    #1;
    checks++;
    if (uv_s !== 1'b0 || uv_w !== 1'b0 || values_s !== '0) begin
      errors++;
      $display("FAIL rstpub_async got v=%b/%b vals=%h exp 0",
               uv_s, uv_w, values_s);
    end
    repeat (2) tick();
    reset = 1'b1;
    upd_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (uv_s !== 1'b0 || obs_s !== exp_all(0)) begin
        errors++;
        $display("FAIL rstpub_quiet got %h exp %h", obs_s, exp_all(0));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) pos[i] = (pos[i] + 1) % 4;
        else if (r == 1) pos[i] = (pos[i] + 3) % 4;
        clear_ch[i] = ($urandom_range(0, 63) == 0);
      end
      set_enc();
      upd_ready = ($urandom_range(0, 9) < 7);
      tick();
      checks++;
      if ({obs_s, obs_w} !== {exp_all(0), exp_all(1)}) begin
        errors++;
        $display("FAIL random t=%0d got %h exp %h", t,
                 {obs_s, obs_w}, {exp_all(0), exp_all(1)});
      end
    end
    clear_ch = '0;
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_saturate();
    test_simultaneous();
    test_backpressure();
    test_clear();
    test_reset_publish();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
